// File: rtl/arm_pkg.sv
// Shared encodings for the single-cycle ARM control path: opcodes, ALU commands,
// ALU control values, condition codes and NZCV bit positions.
package arm_pkg;

  typedef enum logic [1:0] {
    OP_DP    = 2'b00,
    OP_MEM   = 2'b01,
    OP_BR    = 2'b10,
    OP_UNDEF = 2'b11
  } op_e;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_ctrl_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_logic.sv
// Condition evaluation against the registered NZCV flags, the flags register itself,
// and condition gating of the architectural write enables.
module cond_logic
  import arm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  cond_e      i_cond,
  input  logic [3:0] i_alu_flags,
  input  logic [1:0] i_flag_w,
  input  logic       i_pcs,
  input  logic       i_reg_w,
  input  logic       i_no_write,
  input  logic       i_mem_w,
  output logic       o_pc_src,
  output logic       o_reg_write,
  output logic       o_mem_write,
  output logic       o_cond_ex,
  output logic [3:0] o_flags
);

  logic [3:0] r_flags;
  logic       w_cond_ex;
  logic       w_n, w_z, w_c, w_v;

  assign w_n = r_flags[FLAG_N];
  assign w_z = r_flags[FLAG_Z];
  assign w_c = r_flags[FLAG_C];
  assign w_v = r_flags[FLAG_V];

  always_comb begin
    w_cond_ex = 1'b0;
    case (i_cond)
      COND_EQ: w_cond_ex = w_z;
      COND_NE: w_cond_ex = ~w_z;
      COND_CS: w_cond_ex = w_c;
      COND_CC: w_cond_ex = ~w_c;
      COND_MI: w_cond_ex = w_n;
      COND_PL: w_cond_ex = ~w_n;
      COND_VS: w_cond_ex = w_v;
      COND_VC: w_cond_ex = ~w_v;
      COND_HI: w_cond_ex = w_c & ~w_z;
      COND_LS: w_cond_ex = ~w_c | w_z;
      COND_GE: w_cond_ex = (w_n == w_v);
      COND_LT: w_cond_ex = (w_n != w_v);
      COND_GT: w_cond_ex = ~w_z & (w_n == w_v);
      COND_LE: w_cond_ex = w_z | (w_n != w_v);
      COND_AL: w_cond_ex = 1'b1;
      COND_NV: w_cond_ex = 1'b0;
      default: w_cond_ex = 1'b0;
    endcase
  end

  // NZ and CV update independently so logical ops keep the previous carry/overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= 4'b0000;
    end else begin
      if (i_flag_w[1] && w_cond_ex) r_flags[3:2] <= i_alu_flags[3:2];
      if (i_flag_w[0] && w_cond_ex) r_flags[1:0] <= i_alu_flags[1:0];
    end
  end

  assign o_reg_write = i_reg_w & w_cond_ex & ~i_no_write & ~reset;
  assign o_mem_write = i_mem_w & w_cond_ex & ~reset;
  assign o_pc_src    = i_pcs & w_cond_ex & ~reset;
  assign o_cond_ex   = w_cond_ex;
  assign o_flags     = r_flags;

endmodule

// File: rtl/controller.sv
// Single-cycle ARM control unit: main and ALU decoders, PC-write detection and
// retired/skipped performance counters around the cond_logic block.
module controller
  import arm_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [19:0]          Instr,
  input  logic [3:0]           ALUFlags,
  input  logic                 CntClr,
  output logic [1:0]           RegSrc,
  output logic                 RegWrite,
  output logic [1:0]           ImmSrc,
  output logic                 ALUSrc,
  output logic [1:0]           ALUControl,
  output logic                 MemtoReg,
  output logic                 MemWrite,
  output logic                 PCSrc,
  output logic [3:0]           Flags,
  output logic [CNT_WIDTH-1:0] RetiredCount,
  output logic [CNT_WIDTH-1:0] SkippedCount
);

  // Instr holds bits [31:12] of the instruction word, so fields sit 12 bits lower.
  cond_e      w_cond;
  op_e        w_op;
  logic [5:0] w_funct;
  logic [3:0] w_rd;
  logic [3:0] w_cmd;
  logic       w_unused_rn;

  assign w_cond      = cond_e'(Instr[19:16]);
  assign w_op        = op_e'(Instr[15:14]);
  assign w_funct     = Instr[13:8];
  assign w_rd        = Instr[3:0];
  assign w_cmd       = w_funct[4:1];
  assign w_unused_rn = ^Instr[7:4];

  logic       w_branch, w_alu_op, w_reg_w_main, w_mem_w;
  logic       w_reg_w, w_no_write, w_cmd_ok, w_pcs, w_cond_ex;
  logic [1:0] w_flag_w;
  alu_ctrl_e  w_alu_ctrl;

  always_comb begin
    RegSrc       = 2'b00;
    ImmSrc       = 2'b00;
    ALUSrc       = 1'b0;
    MemtoReg     = 1'b0;
    w_reg_w_main = 1'b0;
    w_mem_w      = 1'b0;
    w_branch     = 1'b0;
    w_alu_op     = 1'b0;
    unique case (w_op)
      OP_DP: begin
        ALUSrc       = w_funct[5];
        w_reg_w_main = 1'b1;
        w_alu_op     = 1'b1;
      end
      OP_MEM: begin
        ImmSrc = 2'b01;
        ALUSrc = 1'b1;
        if (w_funct[0]) begin
          MemtoReg     = 1'b1;
          w_reg_w_main = 1'b1;
        end else begin
          RegSrc  = 2'b10;
          w_mem_w = 1'b1;
        end
      end
      OP_BR: begin
        RegSrc   = 2'b01;
        ImmSrc   = 2'b10;
        ALUSrc   = 1'b1;
        w_branch = 1'b1;
      end
      OP_UNDEF: ;
    endcase
  end

  always_comb begin
    w_alu_ctrl = ALU_ADD;
    w_flag_w   = 2'b00;
    w_no_write = 1'b0;
    w_cmd_ok   = 1'b1;
    if (w_alu_op) begin
      case (w_cmd)
        CMD_ADD: w_alu_ctrl = ALU_ADD;
        CMD_SUB: w_alu_ctrl = ALU_SUB;
        CMD_AND: w_alu_ctrl = ALU_AND;
        CMD_ORR: w_alu_ctrl = ALU_ORR;
        CMD_CMP: begin
          w_alu_ctrl = ALU_SUB;
          w_no_write = 1'b1;
        end
        default: w_cmd_ok = 1'b0;
      endcase
      w_flag_w[1] = w_funct[0];
      w_flag_w[0] = w_funct[0] & ((w_cmd == CMD_ADD) | (w_cmd == CMD_SUB) | (w_cmd == CMD_CMP));
    end
  end

  assign w_reg_w    = w_reg_w_main & w_cmd_ok;
  assign w_pcs      = ((w_rd == 4'hF) & w_reg_w) | w_branch;
  assign ALUControl = w_alu_ctrl;

  cond_logic u_cond_logic (
    .clk         (clk),
    .reset       (reset),
    .i_cond      (w_cond),
    .i_alu_flags (ALUFlags),
    .i_flag_w    (w_flag_w),
    .i_pcs       (w_pcs),
    .i_reg_w     (w_reg_w),
    .i_no_write  (w_no_write),
    .i_mem_w     (w_mem_w),
    .o_pc_src    (PCSrc),
    .o_reg_write (RegWrite),
    .o_mem_write (MemWrite),
    .o_cond_ex   (w_cond_ex),
    .o_flags     (Flags)
  );

  logic [CNT_WIDTH-1:0] r_retired, r_skipped;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_retired <= '0;
      r_skipped <= '0;
    end else if (CntClr) begin
      r_retired <= '0;
      r_skipped <= '0;
    end else begin
      r_retired <= r_retired + 1'b1;
      if (!w_cond_ex) r_skipped <= r_skipped + 1'b1;
    end
  end

  assign RetiredCount = r_retired;
  assign SkippedCount = r_skipped;

endmodule

// File: tb/tb_controller.sv
// Directed bench for controller: decode, condition gating, flag updates, async reset
// and counter wrap/clear (a second 4-bit-counter instance covers the wrap).
module tb_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        CntClr;

  logic [1:0]  RegSrc, ImmSrc, ALUControl;
  logic        RegWrite, ALUSrc, MemtoReg, MemWrite, PCSrc;
  logic [3:0]  Flags;
  logic [31:0] RetiredCount, SkippedCount;

  logic [1:0]  s_reg_src, s_imm_src, s_alu_ctrl;
  logic        s_reg_write, s_alu_src, s_mem_to_reg, s_mem_write, s_pc_src;
  logic [3:0]  s_flags;
  logic [3:0]  s_retired, s_skipped;

  controller u_dut (
    .clk          (clk),
    .reset        (reset),
    .Instr        (Instr),
    .ALUFlags     (ALUFlags),
    .CntClr       (CntClr),
    .RegSrc       (RegSrc),
    .RegWrite     (RegWrite),
    .ImmSrc       (ImmSrc),
    .ALUSrc       (ALUSrc),
    .ALUControl   (ALUControl),
    .MemtoReg     (MemtoReg),
    .MemWrite     (MemWrite),
    .PCSrc        (PCSrc),
    .Flags        (Flags),
    .RetiredCount (RetiredCount),
    .SkippedCount (SkippedCount)
  );

  controller #(.CNT_WIDTH(4)) u_dut4 (
    .clk          (clk),
    .reset        (reset),
    .Instr        (Instr),
    .ALUFlags     (ALUFlags),
    .CntClr       (CntClr),
    .RegSrc       (s_reg_src),
    .RegWrite     (s_reg_write),
    .ImmSrc       (s_imm_src),
    .ALUSrc       (s_alu_src),
    .ALUControl   (s_alu_ctrl),
    .MemtoReg     (s_mem_to_reg),
    .MemWrite     (s_mem_write),
    .PCSrc        (s_pc_src),
    .Flags        (s_flags),
    .RetiredCount (s_retired),
    .SkippedCount (s_skipped)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; combinational outputs are sampled 2 ns later.
  task automatic apply(input logic [19:0] ins, input logic [3:0] af);
    Instr    = ins;
    ALUFlags = af;
    #2;
  endtask

  initial begin
    reset    = 1'b1;
    CntClr   = 1'b0;
    Instr    = 20'hE1500;
    ALUFlags = 4'b1111;
    repeat (2) @(negedge clk);
    #2;
    check_eq("rst_flags", Flags, 4'b0000);
    check_eq("rst_retired", RetiredCount, 0);
    check_eq("rst_skipped", SkippedCount, 0);
    check_eq("rst_regwrite", RegWrite, 0);
    check_eq("rst_alucontrol_decodes", ALUControl, 2'b01);

    // A: CMP r0,r0 with ALUFlags 0110
    @(negedge clk);
    reset = 1'b0;
    apply(20'hE1500, 4'b0110);
    check_eq("cmp_regwrite", RegWrite, 0);
    check_eq("cmp_aluctrl", ALUControl, 2'b01);
    check_eq("cmp_pcsrc", PCSrc, 0);

    // B: ADDNE with Z now set -> skipped
    @(negedge clk);
    apply(20'h10811, 4'b0000);
    check_eq("cmp_flags", Flags, 4'b0110);
    check_eq("addne_regwrite", RegWrite, 0);
    check_eq("addne_aluctrl", ALUControl, 2'b00);
    check_eq("retired_after_cmp", RetiredCount, 1);
    check_eq("skipped_before_addne", SkippedCount, 0);

    // C: BEQ with Z=1 -> taken
    @(negedge clk);
    apply(20'h0A000, 4'b0000);
    check_eq("addne_skipped", SkippedCount, 1);
    check_eq("beq_t_pcsrc", PCSrc, 1);
    check_eq("beq_immsrc", ImmSrc, 2'b10);
    check_eq("beq_regsrc", RegSrc, 2'b01);
    check_eq("beq_regwrite", RegWrite, 0);

    // D: CMP clearing flags, E: BEQ with Z=0 -> not taken
    @(negedge clk);
    apply(20'hE1500, 4'b0000);
    @(negedge clk);
    apply(20'h0A000, 4'b0000);
    check_eq("cmp2_flags", Flags, 4'b0000);
    check_eq("beq_nt_pcsrc", PCSrc, 0);

    // F: LDR pc,[r0]
    @(negedge clk);
    apply(20'hE590F, 4'b0000);
    check_eq("beq_nt_skipped", SkippedCount, 2);
    check_eq("ldr_pcsrc", PCSrc, 1);
    check_eq("ldr_memtoreg", MemtoReg, 1);
    check_eq("ldr_regwrite", RegWrite, 1);
    check_eq("ldr_alusrc", ALUSrc, 1);

    // G: STR r1,[r0,#4]
    @(negedge clk);
    apply(20'hE5801, 4'b0000);
    check_eq("str_memwrite", MemWrite, 1);
    check_eq("str_regsrc", RegSrc, 2'b10);
    check_eq("str_regwrite", RegWrite, 0);
    check_eq("str_immsrc", ImmSrc, 2'b01);

    // H: CMP setting 0110, I: ANDS with ALUFlags 1011 -> only NZ updated
    @(negedge clk);
    apply(20'hE1500, 4'b0110);
    @(negedge clk);
    apply(20'hE0121, 4'b1011);
    check_eq("ands_prior_flags", Flags, 4'b0110);
    check_eq("ands_aluctrl", ALUControl, 2'b10);
    check_eq("ands_regwrite", RegWrite, 1);

    // J: undefined op
    @(negedge clk);
    apply(20'hEC000, 4'b0000);
    check_eq("ands_flags", Flags, 4'b1010);
    check_eq("undef_regwrite", RegWrite, 0);
    check_eq("undef_memwrite", MemWrite, 0);
    check_eq("undef_pcsrc", PCSrc, 0);
    check_eq("undef_alusrc", ALUSrc, 0);

    // K: SUB, L: ORR, M: ADDNV (never executes)
    @(negedge clk);
    apply(20'hE0412, 4'b0000);
    check_eq("sub_aluctrl", ALUControl, 2'b01);
    check_eq("sub_regwrite", RegWrite, 1);
    @(negedge clk);
    apply(20'hE1812, 4'b0000);
    check_eq("orr_aluctrl", ALUControl, 2'b11);
    @(negedge clk);
    apply(20'hF0811, 4'b0000);
    check_eq("nv_regwrite", RegWrite, 0);

    // LDR then asynchronous reset between edges
    @(negedge clk);
    apply(20'hE590F, 4'b0000);
    check_eq("retired_13", RetiredCount, 13);
    check_eq("skipped_3", SkippedCount, 3);
    check_eq("pre_rst_regwrite", RegWrite, 1);
    check_eq("pre_rst_flags", Flags, 4'b1010);
    #1;
    reset = 1'b1;
    #1;
    check_eq("arst_flags", Flags, 4'b0000);
    check_eq("arst_retired", RetiredCount, 0);
    check_eq("arst_skipped", SkippedCount, 0);
    check_eq("arst_regwrite", RegWrite, 0);
    check_eq("arst_pcsrc", PCSrc, 0);
    check_eq("arst_memtoreg", MemtoReg, 1);
    check_eq("arst_retired4", s_retired, 0);

    // Counter wrap on the 4-bit instance
    @(negedge clk);
    reset = 1'b0;
    apply(20'hE0412, 4'b0000);
    repeat (15) @(negedge clk);
    #2;
    check_eq("cnt4_15", s_retired, 15);
    @(negedge clk);
    #2;
    check_eq("cnt4_wrap", s_retired, 0);
    check_eq("cnt32_16", RetiredCount, 16);
    check_eq("cnt4_skipped", s_skipped, 0);
    repeat (3) @(negedge clk);
    #2;
    check_eq("cnt4_3", s_retired, 3);
    @(negedge clk);
    CntClr = 1'b1;
    @(negedge clk);
    #2;
    check_eq("clr_retired4", s_retired, 0);
    check_eq("clr_retired32", RetiredCount, 0);
    CntClr = 1'b0;
    @(negedge clk);
    #2;
    check_eq("post_clr_retired", RetiredCount, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
